// File: rtl/dstack_resp.sv
// Data-stack responder: cached TOS register plus a register array for the
// cells below it; ports clk/rst/op/vi in, tos/nos/depth/empty/full/ovf/udf out.
module dstack_resp #(
  parameter  int DSZ   = 32,
  parameter  int DEPTH = 64,
  localparam int SSZ   = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     op,
  input  logic [DSZ-1:0] vi,
  output logic [DSZ-1:0] tos,
  output logic [DSZ-1:0] nos,
  output logic [SSZ-1:0] depth,
  output logic           empty,
  output logic           full,
  output logic           ovf,
  output logic           udf
);

  localparam int AW = $clog2(DEPTH);

  logic [DSZ-1:0] r_t;
  logic [SSZ-1:0] r_depth;
  logic           r_ovf;
  logic           r_udf;
  logic [DSZ-1:0] r_ram [DEPTH-1];

  logic           w_push;
  logic           w_pop;
  logic           w_load;
  logic           w_empty;
  logic           w_full;
  logic           w_ge2;
  logic [SSZ-1:0] w_dm1;
  logic [SSZ-1:0] w_dm2;
  logic [AW-1:0]  w_wa;
  logic [AW-1:0]  w_ra;
  logic [DSZ-1:0] w_rd;

  assign w_push  = (op == 2'b01);
  assign w_pop   = (op == 2'b10);
  assign w_load  = (op == 2'b11);
  assign w_empty = (r_depth == '0);
  assign w_full  = (r_depth == SSZ'(DEPTH));
  assign w_ge2   = (r_depth >= SSZ'(2));
  assign w_dm1   = r_depth - SSZ'(1);
  assign w_dm2   = r_depth - SSZ'(2);
  // Low bits suffice: a write needs depth<=DEPTH-1, a used read depth>=2.
  assign w_wa    = w_dm1[AW-1:0];
  assign w_ra    = w_dm2[AW-1:0];
  assign w_rd    = r_ram[w_ra];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_t     <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      unique case (1'b1)
        w_push: begin
          if (w_full) begin
            r_ovf <= 1'b1;
          end else begin
            r_t     <= vi;
            r_depth <= r_depth + SSZ'(1);
          end
        end
        w_pop: begin
          if (w_empty) begin
            r_udf <= 1'b1;
          end else begin
            r_t     <= w_ge2 ? w_rd : '0;
            r_depth <= w_dm1;
          end
        end
        w_load: begin
          if (w_empty) r_udf <= 1'b1;
          else         r_t   <= vi;
        end
        default: ;
      endcase
    end
  end

  // Array has no reset; its contents are only read below depth.
  always_ff @(posedge clk) begin
    if (!rst && w_push && !w_full && !w_empty) begin
      r_ram[w_wa] <= r_t;
    end
  end

  assign tos   = w_empty ? '0 : r_t;
  assign nos   = w_ge2 ? w_rd : '0;
  assign depth = r_depth;
  assign empty = w_empty;
  assign full  = w_full;
  assign ovf   = r_ovf;
  assign udf   = r_udf;

endmodule

// File: tb/tb_dstack_resp.sv
// Self-checking bench for dstack_resp: queue-based reference stack,
// expected results queued per command and popped after each edge.
module tb_dstack_resp;

  localparam int DSZ   = 32;
  localparam int DEPTH = 64;
  localparam int SSZ   = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DSZ-1:0] tos;
    logic [DSZ-1:0] nos;
    logic [SSZ-1:0] depth;
    logic           empty;
    logic           full;
    logic           ovf;
    logic           udf;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     op;
  logic [DSZ-1:0] vi;
  logic [DSZ-1:0] tos;
  logic [DSZ-1:0] nos;
  logic [SSZ-1:0] depth;
  logic           empty;
  logic           full;
  logic           ovf;
  logic           udf;

  int total = 0;
  int bad   = 0;

  logic [DSZ-1:0] m_stk [$];
  logic           m_ovf = 1'b0;
  logic           m_udf = 1'b0;
  exp_t           sb [$];

  dstack_resp #(.DSZ(DSZ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .op(op), .vi(vi),
    .tos(tos), .nos(nos), .depth(depth),
    .empty(empty), .full(full), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic [1:0] o,
                       input logic [DSZ-1:0] v);
    exp_t e;
    int   n;
    if (r) begin
      m_stk.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      n = m_stk.size();
      case (o)
        2'b01: if (n == DEPTH) m_ovf = 1'b1; else m_stk.push_back(v);
        2'b10: if (n == 0) m_udf = 1'b1; else void'(m_stk.pop_back());
        2'b11: if (n == 0) m_udf = 1'b1; else m_stk[n-1] = v;
        default: ;
      endcase
    end
    n = m_stk.size();
    e.tos   = (n >= 1) ? m_stk[n-1] : '0;
    e.nos   = (n >= 2) ? m_stk[n-2] : '0;
    e.depth = SSZ'(n);
    e.empty = (n == 0);
    e.full  = (n == DEPTH);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic [1:0] o,
                      input logic [DSZ-1:0] v);
    exp_t e;
    rst = r;
    op  = o;
    vi  = v;
    model(r, o, v);
    @(posedge clk);
    #1;
    rst = 1'b0;
    op  = 2'b00;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk("tos",   64'(tos),   64'(e.tos));
      chk("nos",   64'(nos),   64'(e.nos));
      chk("depth", 64'(depth), 64'(e.depth));
      chk("empty", 64'(empty), 64'(e.empty));
      chk("full",  64'(full),  64'(e.full));
      chk("ovf",   64'(ovf),   64'(e.ovf));
      chk("udf",   64'(udf),   64'(e.udf));
    end
  endtask

  initial begin
    rst = 1'b1;
    op  = 2'b00;
    vi  = '0;
    #2;
    step(1, 2'b00, 0);
    step(1, 2'b00, 0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_depth", 64'(depth), 64'd0);

    step(0, 2'b01, 32'h11);
    step(0, 2'b01, 32'h22);
    step(0, 2'b01, 32'h33);
    chk("t1_tos", 64'(tos), 64'h33);
    chk("t1_nos", 64'(nos), 64'h22);
    chk("t1_depth", 64'(depth), 64'd3);

    step(0, 2'b10, 0);
    chk("t2_tos_a", 64'(tos), 64'h22);
    step(0, 2'b10, 0);
    chk("t2_tos_b", 64'(tos), 64'h11);
    step(0, 2'b10, 0);
    chk("t2_tos_c", 64'(tos), 64'h0);
    chk("t2_empty", 64'(empty), 64'd1);
    chk("t2_udf", 64'(udf), 64'd0);

    step(0, 2'b10, 0);
    chk("t3_udf", 64'(udf), 64'd1);
    step(0, 2'b01, 32'h5);
    chk("t3_tos", 64'(tos), 64'h5);
    chk("t3_udf_keep", 64'(udf), 64'd1);

    step(1, 2'b00, 0);
    for (int i = 1; i <= DEPTH; i++) step(0, 2'b01, DSZ'(i));
    chk("t4_full", 64'(full), 64'd1);
    chk("t4_tos", 64'(tos), 64'(DEPTH));
    chk("t4_nos", 64'(nos), 64'(DEPTH-1));
    step(0, 2'b01, 32'hAA);
    chk("t4_ovf", 64'(ovf), 64'd1);
    chk("t4_tos_kept", 64'(tos), 64'(DEPTH));
    for (int i = DEPTH; i >= 1; i--) begin
      chk("t4_pop_val", 64'(tos), 64'(i));
      step(0, 2'b10, 0);
    end
    chk("t4_drained", 64'(empty), 64'd1);

    step(1, 2'b00, 0);
    step(0, 2'b01, 32'h7);
    step(0, 2'b01, 32'h9);
    step(0, 2'b11, 32'h10);
    chk("t5_tos", 64'(tos), 64'h10);
    chk("t5_nos", 64'(nos), 64'h7);
    chk("t5_depth", 64'(depth), 64'd2);
    step(0, 2'b10, 0);
    step(0, 2'b10, 0);
    step(0, 2'b11, 32'h99);
    chk("t5_udf", 64'(udf), 64'd1);
    chk("t5_depth0", 64'(depth), 64'd0);

    step(0, 2'b01, 32'h1);
    step(0, 2'b01, 32'h2);
    step(0, 2'b01, 32'h3);
    step(1, 2'b01, 32'h44);
    chk("t6_depth", 64'(depth), 64'd0);
    chk("t6_tos", 64'(tos), 64'd0);
    chk("t6_flags", 64'({ovf, udf}), 64'd0);
    step(0, 2'b00, 0);
    step(0, 2'b01, 32'hB);
    step(0, 2'b01, 32'hC);
    chk("t6_nos", 64'(nos), 64'hB);

    for (int i = 0; i < 300; i++) begin
      step(0, 2'($urandom_range(0, 3)), DSZ'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
